// File: rtl/hex_display_scanner.sv
// ============================================================================
// Module   : hex_display_scanner
// Brief    : Shows a captured 10-bit value as 3 hex digits on a 4-digit
//            multiplexed common-anode display, updating once per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex_display_scanner #(
    parameter int DIV    = 50000,
    parameter int DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              load_i,
    input  logic              blank_i,
    output logic [6:0]        hex_o,
    output logic [3:0]        an_o,
    output logic              frame_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]  tick_cnt;
    logic [1:0]        dig_idx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] display;
    logic              pending;

    logic              tick;
    logic              wrap;
    logic              commit;
    logic [3:0]        nibble;
    logic              blanked;
    logic [3:0]        an_next;
    logic [6:0]        hex_next;

    // Active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_code(input logic [3:0] val);
        logic [6:0] code;
        case (val)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    assign tick   = (tick_cnt == TICK_LAST);
    assign wrap   = tick && (dig_idx == 2'd3);
    // Display only changes at the frame boundary, so a frame never mixes two values.
    assign commit = wrap && pending;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
            dig_idx  <= 2'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                dig_idx <= dig_idx + 2'd1;
            end
        end
    end

    // A load coincident with the commit still lands in shadow and stays pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= commit;
            if (commit) begin
                display <= shadow;
            end
            if (load_i) begin
                shadow  <= data_i;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble  = 4'h0;
        blanked = 1'b0;
        case (dig_idx)
            2'd0: begin
                nibble = display[3:0];
            end
            2'd1: begin
                nibble  = display[7:4];
                blanked = blank_i && (display[9:4] == 6'd0);
            end
            2'd2: begin
                nibble  = {2'b00, display[9:8]};
                blanked = blank_i && (display[9:8] == 2'd0);
            end
            default: begin
                blanked = 1'b1;
            end
        endcase
        an_next  = blanked ? 4'b1111 : ~(4'b0001 << dig_idx);
        hex_next = blanked ? 7'h7F : seg_code(nibble);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_o  <= 4'b1111;
            hex_o <= 7'h7F;
        end else begin
            an_o  <= an_next;
            hex_o <= hex_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
// ============================================================================
// Module   : tb_hex_display_scanner
// Brief    : Directed self-checking bench for hex_display_scanner (DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_scanner;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic [9:0] data;
    logic       load;
    logic       blank;
    logic [6:0] hex;
    logic [3:0] an;
    logic       frame;

    int total = 0;
    int bad   = 0;
    int cyc;

    hex_display_scanner #(.DIV(DIV), .DATA_W(10)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .load_i  (load),
        .blank_i (blank),
        .hex_o   (hex),
        .an_o    (an),
        .frame_o (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge number since reset release: edge 1 is the first posedge after release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic go_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic next_frame(output int f);
        f = ((cyc / 16) + 1) * 16;
        go_to(f);
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; blank = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'b1111 || hex !== 7'h7F || frame !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got an=%b hex=%h frame=%b want 1111/7f/0", an, hex, frame);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan;
        logic [3:0] ea [4];
        logic [6:0] eh [4];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        eh = '{7'h40, 7'h40, 7'h40, 7'h7F};
        for (int e = 1; e <= 20; e++) begin
            go_to(e);
            total++;
            if (frame !== 1'b0) begin
                bad++;
                $display("FAIL idle_frame cyc=%0d got %b want 0", e, frame);
            end
            if (e < 16 && (e % 4) == 1) begin
                total++;
                if (an !== ea[(e-1)/4] || hex !== eh[(e-1)/4]) begin
                    bad++;
                    $display("FAIL idle_slot%0d got an=%b hex=%h want %b/%h",
                             (e-1)/4, an, hex, ea[(e-1)/4], eh[(e-1)/4]);
                end
            end
        end
    endtask

    task automatic test_single_load;
        int f;
        int pulses;
        logic [3:0] ea [4];
        logic [6:0] eh [4];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        eh = '{7'h79, 7'h40, 7'h24, 7'h7F};
        pulses = 0;
        next_frame(f);
        go_to(f + 5);
        data = 10'h201; load = 1'b1;
        go_to(f + 6);
        load = 1'b0;
        for (int e = f + 6; e <= f + 31; e++) begin
            go_to(e);
            if (frame === 1'b1) pulses++;
            total++;
            if (frame !== (e == f + 16)) begin
                bad++;
                $display("FAIL load513_frame cyc=%0d got %b want %b", e - f, frame, (e == f + 16));
            end
            if (e > f + 16 && ((e - f - 16) % 4) == 2) begin
                total++;
                if (an !== ea[(e-f-16)/4] || hex !== eh[(e-f-16)/4]) begin
                    bad++;
                    $display("FAIL load513_slot%0d got an=%b hex=%h want %b/%h",
                             (e-f-16)/4, an, hex, ea[(e-f-16)/4], eh[(e-f-16)/4]);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL load513_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_full_value;
        int f;
        logic [6:0] eh [3];
        eh = '{7'h0E, 7'h0E, 7'h30};
        next_frame(f);
        go_to(f + 2);
        data = 10'h3FF; load = 1'b1;
        go_to(f + 3);
        load = 1'b0;
        for (int s = 0; s < 3; s++) begin
            go_to(f + 16 + 4*s + 2);
            total++;
            if (hex !== eh[s] || an !== ~(4'b0001 << s)) begin
                bad++;
                $display("FAIL full3ff_digit%0d got an=%b hex=%h want %b/%h",
                         s, an, hex, ~(4'b0001 << s), eh[s]);
            end
        end
    endtask

    task automatic test_blanking;
        int f;
        blank = 1'b1;
        next_frame(f);
        go_to(f + 2);
        data = 10'h00A; load = 1'b1;
        go_to(f + 3);
        load = 1'b0;
        go_to(f + 18);
        total++;
        if (an !== 4'b1110 || hex !== 7'h08) begin
            bad++;
            $display("FAIL blank_digit0 got an=%b hex=%h want 1110/08", an, hex);
        end
        for (int s = 1; s < 3; s++) begin
            go_to(f + 16 + 4*s + 2);
            total++;
            if (an !== 4'b1111 || hex !== 7'h7F) begin
                bad++;
                $display("FAIL blank_on_digit%0d got an=%b hex=%h want 1111/7f", s, an, hex);
            end
        end
        go_to(f + 32);
        blank = 1'b0;
        for (int s = 1; s < 3; s++) begin
            go_to(f + 32 + 4*s + 2);
            total++;
            if (an !== ~(4'b0001 << s) || hex !== 7'h40) begin
                bad++;
                $display("FAIL blank_off_digit%0d got an=%b hex=%h want %b/40",
                         s, an, hex, ~(4'b0001 << s));
            end
        end
    endtask

    task automatic test_back_to_back;
        int f;
        logic [6:0] eh1 [3];
        logic [6:0] eh2 [3];
        eh1 = '{7'h08, 7'h08, 7'h40};
        eh2 = '{7'h79, 7'h46, 7'h30};
        next_frame(f);
        go_to(f + 3);
        data = 10'h155; load = 1'b1;
        go_to(f + 4);
        load = 1'b0;
        go_to(f + 8);
        data = 10'h0AA; load = 1'b1;
        go_to(f + 9);
        load = 1'b0;
        // Captured on the wrap edge itself.
        go_to(f + 15);
        data = 10'h3C1; load = 1'b1;
        go_to(f + 16);
        load = 1'b0;
        total++;
        if (frame !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_pulse got %b want 1", frame);
        end
        for (int s = 0; s < 3; s++) begin
            go_to(f + 16 + 4*s + 2);
            total++;
            if (hex !== eh1[s]) begin
                bad++;
                $display("FAIL b2b_frame1_digit%0d got %h want %h", s, hex, eh1[s]);
            end
        end
        go_to(f + 32);
        total++;
        if (frame !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_pulse got %b want 1", frame);
        end
        for (int s = 0; s < 3; s++) begin
            go_to(f + 32 + 4*s + 2);
            total++;
            if (hex !== eh2[s]) begin
                bad++;
                $display("FAIL b2b_frame2_digit%0d got %h want %h", s, hex, eh2[s]);
            end
        end
        go_to(f + 48);
        total++;
        if (frame !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_third_pulse got %b want 0", frame);
        end
    endtask

    task automatic test_async_reset;
        int f;
        next_frame(f);
        go_to(f + 5);
        data = 10'h155; load = 1'b1;
        go_to(f + 6);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (an !== 4'b1111 || hex !== 7'h7F || frame !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got an=%b hex=%h frame=%b want 1111/7f/0", an, hex, frame);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        go_to(1);
        total++;
        if (an !== 4'b1110 || hex !== 7'h40) begin
            bad++;
            $display("FAIL post_reset_first got an=%b hex=%h want 1110/40", an, hex);
        end
        for (int e = 1; e <= 34; e++) begin
            go_to(e);
            total++;
            if (frame !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_frame cyc=%0d got %b want 0", e, frame);
            end
            if (e > 16 && e < 28 && ((e - 16) % 4) == 2) begin
                total++;
                if (hex !== 7'h40) begin
                    bad++;
                    $display("FAIL post_reset_digit%0d got %h want 40", (e-16)/4, hex);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_load();
        test_full_value();
        test_blanking();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
